// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared encodings and defaults for the mux select controller
//
// Purpose : mode encodings driven on mux_sel_ctrl.mode and the default debounce length.
// Ports   : none (package).
// Config  : MUX_SEL_DEBOUNCE_EN selects the debounced button path in btn_debounce.
`timescale 1ns/1ps

package mux_sel_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_PAUSE  = 2'b10
    } mode_e;

    localparam int DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, optional debouncer and rising-edge pulse
//
// Purpose : turns an asynchronous active-high button into a one-cycle press pulse.
// Config  : MUX_SEL_DEBOUNCE_EN defined   -> level accepted after DEB_CYCLES identical samples.
//           MUX_SEL_DEBOUNCE_EN undefined -> level is the synchronised input itself.
// Ports   : clk      in  system clock
//           rst_n    in  asynchronous active-low reset
//           ena      in  enable; low holds debounce counter, level and edge history
//           btn_raw  in  asynchronous button, active high
//           press    out one-cycle pulse on the 0->1 edge of the debounced level
`timescale 1ns/1ps

module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;

    // Synchroniser keeps sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef MUX_SEL_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    // cnt_q counts consecutive samples that differ from the accepted level;
    // the DEB_CYCLES-th such sample flips the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (ena) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    // Debounce bypassed: every synchronised level is accepted. DEB_CYCLES has
    // no effect here; it appears only in this always-true term.
    localparam logic DEB_ON = (DEB_CYCLES >= 1);

    assign level = sync2_q & DEB_ON;
`endif

    // Edge history only advances with ena, so a press that arrives while the
    // design is held is delivered once ena returns rather than being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
        end else if (ena) begin
            level_prev_q <= level;
        end
    end

    assign press = level & ~level_prev_q;

endmodule

// File: rtl/mux_sel_ctrl.sv
// rtl/mux_sel_ctrl.sv - select generator for the 2:1 output mux (manual / auto scan / pause)
//
// Purpose : drives the mux select from a conditioned push-button or a dwell timer.
// Config  : MUX_SEL_DEBOUNCE_EN enables the button debouncer inside btn_debounce.
// Ports   : clk        in  system clock
//           rst_n      in  asynchronous active-low reset
//           ena        in  enable; low holds FSM, counters and sel, forces sel_toggle low
//           btn_raw    in  asynchronous push-button, active high
//           auto_en    in  asynchronous mode request (1 = auto scan, 0 = manual)
//           dwell      in  auto toggle period minus one, in clocks
//           sel        out registered mux select
//           sel_toggle out one-cycle pulse in the cycle sel takes a new value
//           mode       out 00 MANUAL, 01 AUTO, 10 PAUSE
`timescale 1ns/1ps

module mux_sel_ctrl
    import mux_sel_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               btn_raw,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               sel,
    output logic               sel_toggle,
    output logic [1:0]         mode
);

    logic               press;
    logic               auto_s1_q;
    logic               auto_s2_q;
    mode_e              state_q;
    mode_e              state_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic               sel_q;
    logic               sel_d;
    logic               tog_q;
    logic               tog_d;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .btn_raw (btn_raw),
        .press   (press)
    );

    // Mode request is a level, so a bare synchroniser is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
        end else begin
            auto_s1_q <= auto_en;
            auto_s2_q <= auto_s1_q;
        end
    end

    // Priority inside each state: leaving auto scan beats a press, and a press
    // beats the dwell expiry, so conflicting events never toggle sel.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tog_d   = 1'b0;
        if (ena) begin
            unique case (state_q)
                MODE_MANUAL: begin
                    if (auto_s2_q) begin
                        state_d = MODE_AUTO;
                        cnt_d   = dwell;
                    end else if (press) begin
                        sel_d = ~sel_q;
                        tog_d = 1'b1;
                    end
                end
                MODE_AUTO: begin
                    if (!auto_s2_q) begin
                        state_d = MODE_MANUAL;
                    end else if (press) begin
                        state_d = MODE_PAUSE;
                    end else if (cnt_q == '0) begin
                        sel_d = ~sel_q;
                        tog_d = 1'b1;
                        cnt_d = dwell;
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                MODE_PAUSE: begin
                    if (!auto_s2_q) begin
                        state_d = MODE_MANUAL;
                    end else if (press) begin
                        state_d = MODE_AUTO;
                        cnt_d   = dwell;
                    end
                end
                default: begin
                    state_d = MODE_MANUAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_MANUAL;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tog_q   <= tog_d;
        end
    end

    assign sel        = sel_q;
    assign sel_toggle = tog_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb/tb_mux_sel_ctrl.sv - self-checking bench for mux_sel_ctrl (DEB_CYCLES=4, DWELL_W=8)
`timescale 1ns/1ps

module tb_mux_sel_ctrl;
    import mux_sel_pkg::*;

    localparam int DEB = 4;
`ifdef MUX_SEL_DEBOUNCE_EN
    localparam int LAT            = 2 + DEB + 1;
    localparam int BOUNCE_TOGGLES = 0;
`else
    localparam int LAT            = 3;
    localparam int BOUNCE_TOGGLES = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       btn_raw;
    logic       auto_en;
    logic [7:0] dwell;
    logic       sel;
    logic       sel_toggle;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .DEB_CYCLES (DEB),
        .DWELL_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn_raw    (btn_raw),
        .auto_en    (auto_en),
        .dwell      (dwell),
        .sel        (sel),
        .sel_toggle (sel_toggle),
        .mode       (mode)
    );

    typedef struct {
        logic [7:0] dw;
        int         exp_first;
        int         exp_period;
        int         n_more;
    } auto_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic step_count(input int n, inout int t);
        for (int i = 0; i < n; i++) begin
            tick();
            if (sel_toggle) t++;
        end
    endtask

    task automatic wait_toggle(input string name, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sel_toggle && n < limit);
        chk(name, sel_toggle, 1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ena     = 1'b1;
        btn_raw = 1'b0;
        auto_en = 1'b0;
        dwell   = 8'd0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic enter_auto(input logic [7:0] dw);
        dwell   = dw;
        auto_en = 1'b1;
        ticks(3);
        chk("enter_auto_mode", mode, MODE_AUTO);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        auto_vec_t av[5];
        int        n;
        int        t;
        logic      exp_sel;
        logic      s;

        av[0] = '{8'd0,   1,   1,   4};
        av[1] = '{8'd1,   2,   2,   3};
        av[2] = '{8'd3,   4,   4,   3};
        av[3] = '{8'd10,  11,  11,  2};
        av[4] = '{8'd255, 256, 256, 1};

        // Reset values while rst_n is held low
        rst_n   = 1'b0;
        ena     = 1'b1;
        btn_raw = 1'b0;
        auto_en = 1'b0;
        dwell   = 8'd0;
        ticks(2);
        chk("reset_sel", sel, 0);
        chk("reset_mode", mode, MODE_MANUAL);
        chk("reset_toggle", sel_toggle, 0);
        rst_n = 1'b1;
        tick();

        // Table: auto-scan timing for several dwell values
        for (int v = 0; v < 5; v++) begin
            do_reset();
            dwell   = av[v].dw;
            auto_en = 1'b1;
            ticks(2);
            chk("auto_lat_before", mode, MODE_MANUAL);
            tick();
            chk("auto_lat_3", mode, MODE_AUTO);
            exp_sel = 1'b0;
            wait_toggle("auto_first_seen", 300, n);
            chk("auto_first_gap", n, av[v].exp_first);
            exp_sel = ~exp_sel;
            chk("auto_sel", sel, exp_sel);
            for (int k = 0; k < av[v].n_more; k++) begin
                wait_toggle("auto_period_seen", 300, n);
                chk("auto_period", n, av[v].exp_period);
                exp_sel = ~exp_sel;
                chk("auto_sel", sel, exp_sel);
            end
        end

        // Manual press latency, single toggle, then press again
        do_reset();
        btn_raw = 1'b1;
        ticks(LAT - 1);
        chk("manual_pre_sel", sel, 0);
        tick();
        chk("manual_sel", sel, 1);
        chk("manual_toggle", sel_toggle, 1);
        t = 0;
        step_count(20 - LAT, t);
        chk("manual_single_pulse", t, 0);
        btn_raw = 1'b0;
        t = 0;
        step_count(LAT + 3, t);
        chk("manual_release_no_toggle", t, 0);
        btn_raw = 1'b1;
        ticks(LAT);
        chk("manual_second_sel", sel, 0);
        chk("manual_second_toggle", sel_toggle, 1);
        btn_raw = 1'b0;

        // Bounce: 1,0,1,0 two clocks each, then low
        do_reset();
        t = 0;
        btn_raw = 1'b1; step_count(2, t);
        btn_raw = 1'b0; step_count(2, t);
        btn_raw = 1'b1; step_count(2, t);
        btn_raw = 1'b0; step_count(15, t);
        chk("bounce_toggles", t, BOUNCE_TOGGLES);
        chk("bounce_sel", sel, 0);

        // dwell changed mid-count takes effect at the next reload
        do_reset();
        enter_auto(8'd3);
        wait_toggle("dchg_t1_seen", 50, n);
        chk("dchg_t1_gap", n, 4);
        dwell = 8'd0;
        wait_toggle("dchg_t2_seen", 50, n);
        chk("dchg_t2_gap", n, 4);
        wait_toggle("dchg_t3_seen", 50, n);
        chk("dchg_t3_gap", n, 1);
        wait_toggle("dchg_t4_seen", 50, n);
        chk("dchg_t4_gap", n, 1);

        // Pause lands on the dwell expiry cycle: PAUSE wins, no toggle
        do_reset();
        enter_auto(8'd3);
        wait_toggle("pause_sync_seen", 50, n);
        ticks((4 - (LAT % 4)) % 4);
        btn_raw = 1'b1;
        ticks(LAT - 1);
        chk("pause_pre_mode", mode, MODE_AUTO);
        s = sel;
        tick();
        chk("pause_mode", mode, MODE_PAUSE);
        chk("pause_no_toggle", sel_toggle, 0);
        chk("pause_sel_kept", sel, s);
        btn_raw = 1'b0;
        t = 0;
        step_count(30, t);
        chk("pause_frozen_toggles", t, 0);
        chk("pause_frozen_sel", sel, s);
        chk("pause_still_mode", mode, MODE_PAUSE);
        btn_raw = 1'b1;
        ticks(LAT - 1);
        chk("resume_pre_mode", mode, MODE_PAUSE);
        tick();
        chk("resume_mode", mode, MODE_AUTO);
        wait_toggle("resume_first_seen", 50, n);
        chk("resume_first_gap", n, 4);
        btn_raw = 1'b0;

        // auto_en falling coincides with press: MANUAL, no toggle, no PAUSE
        do_reset();
        enter_auto(8'd3);
        btn_raw = 1'b1;
        ticks(LAT - 3);
        auto_en = 1'b0;
        ticks(2);
        chk("conflict_pre_mode", mode, MODE_AUTO);
        s = sel;
        tick();
        chk("conflict_mode", mode, MODE_MANUAL);
        chk("conflict_no_toggle", sel_toggle, 0);
        chk("conflict_sel_kept", sel, s);
        t = 0;
        step_count(5, t);
        chk("conflict_after_toggles", t, 0);
        btn_raw = 1'b0;

        // ena low in AUTO: counter holds and resumes
        do_reset();
        enter_auto(8'd7);
        wait_toggle("ena_sync_seen", 50, n);
        chk("ena_sync_gap", n, 8);
        ticks(2);
        ena = 1'b0;
        s = sel;
        t = 0;
        step_count(10, t);
        chk("ena_hold_toggles", t, 0);
        chk("ena_hold_sel", sel, s);
        chk("ena_hold_mode", mode, MODE_AUTO);
        ena = 1'b1;
        wait_toggle("ena_resume_seen", 50, n);
        chk("ena_resume_gap", n, 6);

        // Asynchronous reset mid-AUTO clears outputs immediately
        do_reset();
        enter_auto(8'd0);
        wait_toggle("arst_sync_seen", 50, n);
        chk("arst_pre_sel", sel, 1);
        #2;
        rst_n   = 1'b0;
        auto_en = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_mode", mode, MODE_MANUAL);
        chk("arst_toggle", sel_toggle, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // A press one edge from the FSM is discarded by reset
        btn_raw = 1'b1;
        ticks(LAT - 1);
        #2;
        rst_n = 1'b0;
        #1;
        btn_raw = 1'b0;
        tick();
        rst_n = 1'b1;
        t = 0;
        step_count(LAT + 5, t);
        chk("arst_press_dropped", t, 0);
        chk("arst_press_sel", sel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
